// File: rtl/dcache_bus_serializer_pkg.sv
// Shared types and widths for the D-cache line-to-bus serializer.
// Provides the line/bus geometry, the derived beat counts, and the
// packed payload latched at the start of a line write.
package dcache_bus_serializer_pkg;

  localparam int unsigned LINE_WIDTH       = 128;
  localparam int unsigned BUS_WIDTH        = 32;
  localparam int unsigned MEM_ADDR_WIDTH   = 26;
  localparam int unsigned BEAT_COUNT       = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned BEAT_INDEX_WIDTH = $clog2(BEAT_COUNT);
  // One extra bit so a counter can hold BEAT_COUNT itself.
  localparam int unsigned CNT_WIDTH        = BEAT_INDEX_WIDTH + 1;
  localparam int unsigned BUS_ADDR_WIDTH   = MEM_ADDR_WIDTH + BEAT_INDEX_WIDTH;

  typedef logic [LINE_WIDTH-1:0]       line_t;
  typedef logic [BUS_WIDTH-1:0]        bus_data_t;
  typedef logic [MEM_ADDR_WIDTH-1:0]   mem_addr_t;
  typedef logic [BUS_ADDR_WIDTH-1:0]   bus_addr_t;
  typedef logic [BEAT_INDEX_WIDTH-1:0] beat_idx_t;
  typedef logic [CNT_WIDTH-1:0]        beat_cnt_t;

  // Request captured from the replacer when a line operation starts.
  typedef struct packed {
    mem_addr_t addr;
    line_t     data;
  } line_req_t;

  // Beat slice of a line; beat 0 is the least significant slice.
  function automatic bus_data_t line_slice(input line_t line, input beat_idx_t idx);
    return line[int'(idx)*BUS_WIDTH +: BUS_WIDTH];
  endfunction

endpackage

// File: rtl/dcache_bus_serializer_if.sv
// Replacer-facing line port plus narrow memory bus port of the serializer.
// master: the serializer (consumes line requests, issues bus beats).
// slave : the environment (replacer + memory bus).
//   memAddr/memReadEnable/memWriteEnable/memWriteValue : line request
//   memReadDone/memWriteDone/memReadValue             : line completion
//   busValid/busWrite/busAddr/busWriteData/busReady    : beat request
//   busReadDataValid/busReadData                       : returned read beats
interface dcache_bus_serializer_if;
  import dcache_bus_serializer_pkg::*;

  mem_addr_t memAddr;
  logic      memReadEnable;
  logic      memWriteEnable;
  line_t     memWriteValue;
  logic      memReadDone;
  logic      memWriteDone;
  line_t     memReadValue;

  logic      busValid;
  logic      busWrite;
  bus_addr_t busAddr;
  bus_data_t busWriteData;
  logic      busReady;
  logic      busReadDataValid;
  bus_data_t busReadData;

  modport master (
    input  memAddr, memReadEnable, memWriteEnable, memWriteValue,
    input  busReady, busReadDataValid, busReadData,
    output memReadDone, memWriteDone, memReadValue,
    output busValid, busWrite, busAddr, busWriteData
  );

  modport slave (
    output memAddr, memReadEnable, memWriteEnable, memWriteValue,
    output busReady, busReadDataValid, busReadData,
    input  memReadDone, memWriteDone, memReadValue,
    input  busValid, busWrite, busAddr, busWriteData
  );

endinterface

// File: rtl/dcache_bus_serializer.sv
// Serializes line-wide D-cache read/write requests into BEAT_COUNT narrow
// bus beats and reassembles read beats into a full line.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   ifc - master view of the line/bus interface
// All outputs come straight from registers; bus inputs only reach outputs
// through a clock edge.
module dcache_bus_serializer
  import dcache_bus_serializer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  dcache_bus_serializer_if.master  ifc
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam beat_cnt_t CNT_ONE  = CNT_WIDTH'(1);
  localparam beat_cnt_t CNT_LAST = CNT_WIDTH'(BEAT_COUNT - 1);
  localparam beat_cnt_t CNT_FULL = CNT_WIDTH'(BEAT_COUNT);

  state_e    state_q, state_d;
  beat_cnt_t issue_q, issue_d;
  beat_cnt_t ret_q, ret_d;
  line_req_t req_q, req_d;
  line_t     rline_q, rline_d;

  logic      bus_valid_q, bus_valid_d;
  logic      bus_write_q, bus_write_d;
  bus_addr_t bus_addr_q, bus_addr_d;
  bus_data_t bus_wdata_q, bus_wdata_d;
  logic      rd_done_q, rd_done_d;
  logic      wr_done_q, wr_done_d;

  logic      accept;

  // Next-state, counters, line buffer and registered-output decode.
  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    ret_d       = ret_q;
    req_d       = req_q;
    rline_d     = rline_q;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    bus_valid_d = 1'b0;
    bus_write_d = 1'b0;
    bus_addr_d  = '0;
    bus_wdata_d = '0;

    accept = bus_valid_q && ifc.busReady;

    case (state_q)
      ST_IDLE: begin
        // Write wins when both enables are raised together.
        if (ifc.memWriteEnable) begin
          req_d.addr = ifc.memAddr;
          req_d.data = ifc.memWriteValue;
          issue_d    = '0;
          ret_d      = '0;
          state_d    = ST_WRITE;
        end else if (ifc.memReadEnable) begin
          req_d.addr = ifc.memAddr;
          issue_d    = '0;
          ret_d      = '0;
          state_d    = ST_READ;
        end
      end

      ST_WRITE: begin
        if (accept) begin
          issue_d = issue_q + CNT_ONE;
          if (issue_q == CNT_LAST) begin
            state_d   = ST_DONE;
            wr_done_d = 1'b1;
          end
        end
      end

      ST_READ: begin
        // Requests are pipelined independently of the returning data.
        if (accept) begin
          issue_d = issue_q + CNT_ONE;
        end
        if (ifc.busReadDataValid && (ret_q < CNT_FULL)) begin
          rline_d[int'(ret_q[BEAT_INDEX_WIDTH-1:0])*BUS_WIDTH +: BUS_WIDTH] = ifc.busReadData;
          ret_d = ret_q + CNT_ONE;
          if (ret_q == CNT_LAST) begin
            state_d   = ST_DONE;
            rd_done_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus request is decoded from the next-cycle view so it registers in step with it.
    if (state_d == ST_WRITE) begin
      bus_valid_d = 1'b1;
      bus_write_d = 1'b1;
      bus_addr_d  = {req_d.addr, issue_d[BEAT_INDEX_WIDTH-1:0]};
      bus_wdata_d = line_slice(req_d.data, issue_d[BEAT_INDEX_WIDTH-1:0]);
    end else if ((state_d == ST_READ) && (issue_d < CNT_FULL)) begin
      bus_valid_d = 1'b1;
      bus_addr_d  = {req_d.addr, issue_d[BEAT_INDEX_WIDTH-1:0]};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_q     <= '0;
      ret_q       <= '0;
      req_q       <= '0;
      rline_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      ret_q       <= ret_d;
      req_q       <= req_d;
      rline_q     <= rline_d;
      bus_valid_q <= bus_valid_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign ifc.busValid     = bus_valid_q;
  assign ifc.busWrite     = bus_write_q;
  assign ifc.busAddr      = bus_addr_q;
  assign ifc.busWriteData = bus_wdata_q;
  assign ifc.memReadDone  = rd_done_q;
  assign ifc.memWriteDone = wr_done_q;
  assign ifc.memReadValue = rline_q;

endmodule

// File: tb/tb_dcache_bus_serializer.sv
// Self-checking bench for dcache_bus_serializer: a transaction-level model
// (expected beat queue, memory line, in-order return queue) checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_dcache_bus_serializer;
  import dcache_bus_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst;

  dcache_bus_serializer_if ifc();

  dcache_bus_serializer dut (
    .clk (clk),
    .rst (rst),
    .ifc (ifc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bus_addr_t addr;
    logic      wr;
    bus_data_t data;
  } beat_t;

  typedef struct {
    int        due;
    bus_data_t data;
  } ret_t;

  beat_t     exp_q[$];       // beats the DUT must issue, in order
  ret_t      ret_q[$];       // read data the memory owes, in order
  bus_addr_t acc_addr[$];    // log of accepted beats
  bus_data_t acc_data[$];
  line_t     exp_rd_line = '0;
  int        exp_wr_done_cyc = -1;
  int        exp_rd_done_cyc = -1;
  int        ret_total = 0;
  int        ret_base  = 0;
  int        wr_done_cnt = 0;
  int        rd_done_cnt = 0;
  int        ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 manual
  logic      man_ready  = 1'b1;
  int        lat        = 1;
  int        op_start   = 0;

  // Memory-side responder: drives ready and returns owed read beats.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ifc.busReady = 1'b1;
      1:       ifc.busReady = (((cyc - op_start) % 2) == 1);
      2:       ifc.busReady = ($urandom_range(0, 3) != 0);
      default: ifc.busReady = man_ready;
    endcase
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      ifc.busReadDataValid = 1'b1;
      ifc.busReadData      = ret_q[0].data;
      ret_q.pop_front();
      ret_total++;
      if (ret_total - ret_base == int'(BEAT_COUNT)) exp_rd_done_cyc = cyc + 1;
    end else begin
      ifc.busReadDataValid = 1'b0;
      ifc.busReadData      = bus_data_t'($urandom);
    end
  end

  // Per-cycle compare of DUT outputs against the transaction model.
  logic      prev_stall = 1'b0;
  bus_addr_t prev_addr  = '0;
  beat_t     e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 128'(ifc.busValid), 128'(1));
        check("stall_addr", 128'(ifc.busAddr), 128'(prev_addr));
      end
      check("wr_done_timing", 128'(ifc.memWriteDone), 128'(cyc == exp_wr_done_cyc));
      check("rd_done_timing", 128'(ifc.memReadDone), 128'(cyc == exp_rd_done_cyc));
      if (ifc.memWriteDone) wr_done_cnt++;
      if (ifc.memReadDone) begin
        rd_done_cnt++;
        check("rd_line", 128'(ifc.memReadValue), 128'(exp_rd_line));
      end
      if (ifc.busValid) begin
        if (exp_q.size() == 0) begin
          check("req_expected", 128'(exp_q.size() > 0), 128'(1));
        end else if (ifc.busReady) begin
          e = exp_q.pop_front();
          check("bus_addr", 128'(ifc.busAddr), 128'(e.addr));
          check("bus_write", 128'(ifc.busWrite), 128'(e.wr));
          if (e.wr) check("bus_wdata", 128'(ifc.busWriteData), 128'(e.data));
          else ret_q.push_back('{cyc + lat, e.data});
          acc_addr.push_back(ifc.busAddr);
          acc_data.push_back(ifc.busWriteData);
          if (e.wr && exp_q.size() == 0) exp_wr_done_cyc = cyc + 1;
        end
      end
      prev_stall = ifc.busValid && !ifc.busReady;
      prev_addr  = ifc.busAddr;
    end
  end

  // Runs one line operation; called and returns just after a rising edge.
  task automatic run_op(input logic wr, input logic rd, input mem_addr_t a,
                        input line_t wline, input line_t rline, output int latency);
    for (int i = 0; i < int'(BEAT_COUNT); i++) begin
      if (wr) exp_q.push_back('{{a, BEAT_INDEX_WIDTH'(i)}, 1'b1, wline[i*BUS_WIDTH +: BUS_WIDTH]});
      else    exp_q.push_back('{{a, BEAT_INDEX_WIDTH'(i)}, 1'b0, rline[i*BUS_WIDTH +: BUS_WIDTH]});
    end
    if (!wr) exp_rd_line = rline;
    ret_base = ret_total;
    op_start = cyc;
    ifc.memAddr        = a;
    ifc.memWriteValue  = wline;
    ifc.memWriteEnable = wr;
    ifc.memReadEnable  = rd;
    // The request is latched at start; later changes must not matter.
    @(posedge clk); #1;
    ifc.memAddr       = mem_addr_t'($urandom);
    ifc.memWriteValue = {$urandom, $urandom, $urandom, $urandom};
    latency = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ifc.memWriteDone || ifc.memReadDone) begin
        latency = cyc - op_start;
        break;
      end
    end
    check("op_completed", 128'(latency >= 0), 128'(1));
    @(posedge clk); #1;
    ifc.memWriteEnable = 1'b0;
    ifc.memReadEnable  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int    l;
    int    wr_before, rd_before, wr_exp, rd_exp;
    line_t wl, rl;
    logic  w, r;

    rst = 1'b1;
    ifc.memAddr        = '0;
    ifc.memReadEnable  = 1'b0;
    ifc.memWriteEnable = 1'b0;
    ifc.memWriteValue  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busValid", 128'(ifc.busValid), 128'(0));
    check("rst_busWrite", 128'(ifc.busWrite), 128'(0));
    check("rst_busAddr", 128'(ifc.busAddr), 128'(0));
    check("rst_busWriteData", 128'(ifc.busWriteData), 128'(0));
    check("rst_memReadDone", 128'(ifc.memReadDone), 128'(0));
    check("rst_memWriteDone", 128'(ifc.memWriteDone), 128'(0));
    check("rst_memReadValue", 128'(ifc.memReadValue), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed write with literal beats and latency.
    ready_mode = 0; lat = 1;
    acc_addr.delete(); acc_data.delete();
    wr_before = wr_done_cnt;
    run_op(1'b1, 1'b0, 26'h000010, 128'h44444444_33333333_22222222_11111111, '0, l);
    check("wr_latency", 128'(l), 128'(5));
    check("wr_beat_count", 128'(acc_addr.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      check("wr_lit_addr", 128'(acc_addr[i]), 128'(28'h40 + 28'(i)));
      check("wr_lit_data", 128'(acc_data[i]), 128'(32'h11111111 * 32'(i + 1)));
    end
    check("wr_done_once", 128'(wr_done_cnt - wr_before), 128'(1));

    // Directed read with 1-cycle return.
    rd_before = rd_done_cnt;
    run_op(1'b0, 1'b1, 26'h0ABCDE, '0, 128'h000000A3_000000A2_000000A1_000000A0, l);
    check("rd_latency", 128'(l), 128'(6));
    check("rd_lit_value", 128'(ifc.memReadValue), 128'h000000A3_000000A2_000000A1_000000A0);
    check("rd_done_once", 128'(rd_done_cnt - rd_before), 128'(1));

    // Read with toggling ready and 3-cycle return latency.
    ready_mode = 1; lat = 3;
    rl = {$urandom, $urandom, $urandom, $urandom};
    rd_before = rd_done_cnt;
    run_op(1'b0, 1'b1, mem_addr_t'($urandom), '0, rl, l);
    check("stall_rd_value", 128'(ifc.memReadValue), 128'(rl));
    check("stall_rd_done_once", 128'(rd_done_cnt - rd_before), 128'(1));

    // Both enables together: only the write runs.
    ready_mode = 0; lat = 1;
    rd_before = rd_done_cnt; wr_before = wr_done_cnt;
    run_op(1'b1, 1'b1, mem_addr_t'($urandom), {$urandom, $urandom, $urandom, $urandom}, '0, l);
    check("both_wr_done", 128'(wr_done_cnt - wr_before), 128'(1));
    check("both_no_rd_done", 128'(rd_done_cnt - rd_before), 128'(0));

    // Reset mid-read, then stray return beats.
    ready_mode = 3; man_ready = 1'b1; lat = 50;
    rd_before = rd_done_cnt;
    for (int i = 0; i < int'(BEAT_COUNT); i++)
      exp_q.push_back('{{26'h155, BEAT_INDEX_WIDTH'(i)}, 1'b0, 32'hDEAD0000 + 32'(i)});
    ifc.memAddr       = 26'h155;
    ifc.memReadEnable = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_accepts", 128'(acc_addr.size() >= 2), 128'(1));
    rst = 1'b1;
    ifc.memReadEnable = 1'b0;
    exp_q.delete();
    ret_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    man_ready = 1'b0;
    ret_base = ret_total;
    ret_q.push_back('{cyc, 32'hBAD00001});
    ret_q.push_back('{cyc + 1, 32'hBAD00002});
    repeat (2) begin
      @(negedge clk);
      check("post_rst_idle", 128'(ifc.busValid), 128'(0));
    end
    repeat (4) @(negedge clk);
    check("post_rst_rdvalue", 128'(ifc.memReadValue), 128'(0));
    check("post_rst_no_done", 128'(rd_done_cnt - rd_before), 128'(0));
    @(posedge clk); #1;

    // Back-to-back write then read.
    ready_mode = 0; lat = 1;
    wl = {$urandom, $urandom, $urandom, $urandom};
    rl = ~wl ^ {$urandom, 96'h0};
    wr_before = wr_done_cnt; rd_before = rd_done_cnt;
    run_op(1'b1, 1'b0, mem_addr_t'($urandom), wl, '0, l);
    run_op(1'b0, 1'b1, mem_addr_t'($urandom), '0, rl, l);
    check("b2b_wr_done", 128'(wr_done_cnt - wr_before), 128'(1));
    check("b2b_rd_done", 128'(rd_done_cnt - rd_before), 128'(1));
    check("b2b_rd_value", 128'(ifc.memReadValue), 128'(rl));
    check("b2b_not_wdata", 128'(ifc.memReadValue != wl), 128'(1));

    // Randomized operations with random ready and return latency.
    ready_mode = 2;
    wr_exp = wr_done_cnt; rd_exp = rd_done_cnt;
    for (int n = 0; n < 30; n++) begin
      lat = $urandom_range(1, 4);
      w   = 1'($urandom_range(0, 1));
      r   = w ? 1'($urandom_range(0, 1)) : 1'b1;
      wl  = {$urandom, $urandom, $urandom, $urandom};
      rl  = {$urandom, $urandom, $urandom, $urandom};
      run_op(w, r, mem_addr_t'($urandom), wl, rl, l);
      if (w) wr_exp++;
      else   rd_exp++;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    repeat (3) @(negedge clk);
    check("rand_wr_done_total", 128'(wr_done_cnt), 128'(wr_exp));
    check("rand_rd_done_total", 128'(rd_done_cnt), 128'(rd_exp));
    check("rand_exp_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
